// File: rtl/branch_history_predictor.sv
// branch_history_predictor
// gshare-style conditional-branch predictor. A table of 2-bit saturating
// counters is indexed by pc[INDEX_BITS+1:2] XOR the global history. The
// fetch stage receives a registered prediction one cycle after its request.
// The execute stage trains the table and the (non-speculative) history with
// resolved outcomes. After reset, a sweep writes every counter to weak
// not-taken before the predictor reports ready.

module branch_history_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                predict_req,
  input  logic [31:0]         predict_pc,
  output logic                predict_valid,
  output logic                predict_taken,
  output logic [GHR_BITS-1:0] predict_ghr,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                update_taken,
  input  logic                update_pred,
  output logic                mispredict,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  // History must fit inside the index it is folded into.
  if (GHR_BITS > INDEX_BITS || GHR_BITS < 1) begin : g_bad_params
    $error("branch_history_predictor: GHR_BITS must be in 1..INDEX_BITS");
  end

  logic [0:0]            state_q;
  logic [INDEX_BITS-1:0] sweep_ptr;
  logic [GHR_BITS-1:0]   ghr;
  logic [GHR_BITS:0]     ghr_shifted;

  logic [1:0]            pht [DEPTH];

  logic                  in_ready;
  logic                  lookup_accept;
  logic                  update_accept;
  logic                  update_wrong;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [1:0]            update_ctr;
  logic [1:0]            update_ctr_next;

  logic                  pht_we;
  logic [INDEX_BITS-1:0] pht_waddr;
  logic [1:0]            pht_wdata;

  // Only the PC bits that select a table entry are used; the byte offset
  // and the high bits are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{predict_pc[31:INDEX_BITS+2], predict_pc[1:0],
                            update_pc[31:INDEX_BITS+2], update_pc[1:0]};

  assign in_ready      = (state_q == ST_READY);
  assign ready         = in_ready;
  assign lookup_accept = predict_req  & in_ready;
  assign update_accept = update_valid & in_ready;
  assign update_wrong  = update_taken ^ update_pred;

  // Lookups fold in the live history; updates fold in the snapshot that was
  // handed out with the prediction, so both land on the same entry.
  assign lookup_idx = predict_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  assign update_idx = update_pc[INDEX_BITS+1:2]  ^ INDEX_BITS'(update_ghr);

  assign update_ctr  = pht[update_idx];
  assign ghr_shifted = {ghr, update_taken};

  // Saturating increment on taken, saturating decrement on not-taken.
  always_comb begin
    update_ctr_next = update_ctr;
    if (update_taken) begin
      if (update_ctr != 2'b11) begin
        update_ctr_next = update_ctr + 2'b01;
      end
    end else begin
      if (update_ctr != 2'b00) begin
        update_ctr_next = update_ctr - 2'b01;
      end
    end
  end

  // Single table write port, shared between the init sweep and training.
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = sweep_ptr;
    pht_wdata = CTR_WEAK_NT;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        pht_we = 1'b1;
      end else if (update_accept) begin
        pht_we    = 1'b1;
        pht_waddr = update_idx;
        pht_wdata = update_ctr_next;
      end
    end
  end

  // INIT/READY sequencing: sweep every entry once, then serve requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      sweep_ptr <= '0;
    end else if (state_q == ST_INIT) begin
      sweep_ptr <= sweep_ptr + 1'b1;
      if (&sweep_ptr) begin
        state_q <= ST_READY;
      end
    end
  end

  // Counter table storage; no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (pht_we) begin
      pht[pht_waddr] <= pht_wdata;
    end
  end

  // Registered lookup; reads the pre-update counter on an index collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      predict_valid <= 1'b0;
      predict_taken <= 1'b0;
      predict_ghr   <= '0;
    end else begin
      predict_valid <= lookup_accept;
      if (lookup_accept) begin
        predict_taken <= pht[lookup_idx][1];
        predict_ghr   <= ghr;
      end
    end
  end

  // Global history shifts in resolved outcomes only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (update_accept) begin
      ghr <= ghr_shifted[GHR_BITS-1:0];
    end
  end

  // Branch and mispredict statistics, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict       <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= update_accept & update_wrong;
      if (update_accept && (branch_count != 32'hFFFF_FFFF)) begin
        branch_count <= branch_count + 32'd1;
      end
      if (update_accept && update_wrong &&
          (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// tb_branch_history_predictor
// Directed scenarios plus randomized traffic for branch_history_predictor,
// checked every cycle against a behavioural model of the predictor.

module tb_branch_history_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        predict_req;
  logic [31:0] predict_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic [3:0]  predict_ghr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [3:0]  update_ghr;
  logic        update_taken;
  logic        update_pred;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int compared   = 0;
  int mismatched = 0;

  // Model state
  int          m_pht [64];
  int          m_init_cnt;
  bit          m_ready;
  bit          m_live = 1'b0;
  int          m_ghr;
  longint      m_branches;
  longint      m_misses;
  bit          e_valid;
  bit          e_taken;
  int          e_ghr;
  bit          e_mis;

  branch_history_predictor #(.INDEX_BITS(6), .GHR_BITS(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .ready            (ready),
    .predict_req      (predict_req),
    .predict_pc       (predict_pc),
    .predict_valid    (predict_valid),
    .predict_taken    (predict_taken),
    .predict_ghr      (predict_ghr),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_pred      (update_pred),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  // One comparison; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled
  function automatic void modelStep();
    int li;
    int ui;
    if (reset) begin
      m_live     = 1'b1;
      m_init_cnt = 0;
      m_ready    = 1'b0;
      m_ghr      = 0;
      m_branches = 0;
      m_misses   = 0;
      e_valid    = 1'b0;
      e_taken    = 1'b0;
      e_ghr      = 0;
      e_mis      = 1'b0;
      return;
    end
    if (!m_live) return;
    if (!m_ready) begin
      e_valid = 1'b0;
      e_mis   = 1'b0;
      m_init_cnt++;
      if (m_init_cnt == 64) begin
        m_ready = 1'b1;
        foreach (m_pht[i]) m_pht[i] = 1;
      end
      return;
    end
    li = ((int'(predict_pc) >>> 2) & 63) ^ m_ghr;
    e_valid = predict_req;
    if (predict_req) begin
      e_taken = (m_pht[li] >= 2);
      e_ghr   = m_ghr;
    end
    e_mis = 1'b0;
    if (update_valid) begin
      ui = ((int'(update_pc) >>> 2) & 63) ^ int'(update_ghr);
      if (update_taken) m_pht[ui] = (m_pht[ui] < 3) ? m_pht[ui] + 1 : 3;
      else              m_pht[ui] = (m_pht[ui] > 0) ? m_pht[ui] - 1 : 0;
      m_ghr = ((m_ghr * 2) + int'(update_taken)) % 16;
      if (m_branches < 64'hFFFF_FFFF) m_branches++;
      if (update_taken != update_pred) begin
        e_mis = 1'b1;
        if (m_misses < 64'hFFFF_FFFF) m_misses++;
      end
    end
  endfunction

  // Drive one cycle of inputs at the falling edge, then step the model
  task automatic applyStimulus(input bit rst, input bit req,
                               input logic [31:0] ppc, input bit uv,
                               input logic [31:0] upc, input logic [3:0] ug,
                               input bit ut, input bit up);
    @(negedge clk);
    reset        = rst;
    predict_req  = req;
    predict_pc   = ppc;
    update_valid = uv;
    update_pc    = upc;
    update_ghr   = ug;
    update_taken = ut;
    update_pred  = up;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("ready", 32'(ready), 32'(m_ready));
      checkOutput("predict_valid", 32'(predict_valid), 32'(e_valid));
      checkOutput("mispredict", 32'(mispredict), 32'(e_mis));
      checkOutput("branch_count", branch_count, 32'(m_branches));
      checkOutput("mispredict_count", mispredict_count, 32'(m_misses));
      if (e_valid) begin
        checkOutput("predict_taken", 32'(predict_taken), 32'(e_taken));
        checkOutput("predict_ghr", 32'(predict_ghr), 32'(e_ghr));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit rr;
    bit rq;
    bit ru;
    reset        = 1'b1;
    predict_req  = 1'b0;
    predict_pc   = '0;
    update_valid = 1'b0;
    update_pc    = '0;
    update_ghr   = '0;
    update_taken = 1'b0;
    update_pred  = 1'b0;

    // Test 1: reset state and init sweep
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h104, 1, 32'h104, 0, 1, 0);
    checkOutput("reset_ready", 32'(ready), 0);
    checkOutput("reset_valid", 32'(predict_valid), 0);
    checkOutput("reset_taken", 32'(predict_taken), 0);
    checkOutput("reset_ghr", 32'(predict_ghr), 0);
    checkOutput("reset_mispredict", 32'(mispredict), 0);
    checkOutput("reset_branch_count", branch_count, 0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 1, $urandom, 1, $urandom, 4'($urandom), 1, 0);
      if (i < 63) checkOutput("init_ready_low", 32'(ready), 0);
      checkOutput("init_valid_low", 32'(predict_valid), 0);
    end
    checkOutput("init_ready_high", 32'(ready), 1);
    checkOutput("init_branch_count", branch_count, 0);
    applyStimulus(0, 1, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("first_valid", 32'(predict_valid), 1);
    checkOutput("first_taken", 32'(predict_taken), 0);
    checkOutput("first_ghr", 32'(predict_ghr), 0);

    // Test 2: training index 1 from weak not-taken to strong taken
    applyStimulus(0, 0, 0, 1, 32'h104, 0, 1, 0);
    checkOutput("train1_mispredict", 32'(mispredict), 1);
    applyStimulus(0, 0, 0, 1, 32'h104, 0, 1, 0);
    checkOutput("train2_mispredict", 32'(mispredict), 1);
    applyStimulus(0, 1, 32'h108, 0, 0, 0, 0, 0);
    checkOutput("train_mispredict_clear", 32'(mispredict), 0);
    checkOutput("train_taken", 32'(predict_taken), 1);
    checkOutput("train_ghr", 32'(predict_ghr), 32'h3);
    checkOutput("train_branch_count", branch_count, 2);
    checkOutput("train_mispredict_count", mispredict_count, 2);

    // Test 3: saturation and hysteresis on index 1
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 32'h104, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 32'h104, 0, 0, 1);
    applyStimulus(0, 1, 32'((1 ^ m_ghr) << 2), 0, 0, 0, 0, 0);
    checkOutput("hyst_one_nt_taken", 32'(predict_taken), 1);
    checkOutput("hyst_one_nt_ghr", 32'(predict_ghr), 32'hE);
    applyStimulus(0, 0, 0, 1, 32'h104, 0, 0, 1);
    applyStimulus(0, 1, 32'((1 ^ m_ghr) << 2), 0, 0, 0, 0, 0);
    checkOutput("hyst_two_nt_taken", 32'(predict_taken), 0);
    checkOutput("hyst_two_nt_ghr", 32'(predict_ghr), 32'hC);

    // Test 4: correct prediction leaves the mispredict statistics alone
    applyStimulus(0, 0, 0, 1, 32'h104, 0, 1, 1);
    checkOutput("correct_mispredict", 32'(mispredict), 0);
    checkOutput("correct_branch_count", branch_count, 9);
    checkOutput("correct_mispredict_count", mispredict_count, 4);
    applyStimulus(0, 0, 0, 1, 32'h104, 0, 1, 1);
    checkOutput("correct2_branch_count", branch_count, 10);

    // Test 5: same-cycle predict and update on the same entry
    applyStimulus(0, 1, 32'h108, 1, 32'h104, 0, 0, 1);
    checkOutput("collide_taken", 32'(predict_taken), 1);
    checkOutput("collide_ghr", 32'(predict_ghr), 32'h3);
    checkOutput("collide_mispredict", 32'(mispredict), 1);
    applyStimulus(0, 1, 32'h1C, 0, 0, 0, 0, 0);
    checkOutput("after_collide_taken", 32'(predict_taken), 1);
    checkOutput("after_collide_ghr", 32'(predict_ghr), 32'h6);
    checkOutput("after_collide_branch_count", branch_count, 11);
    checkOutput("after_collide_mispredict_count", mispredict_count, 5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 399) == 0);
      rq = ($urandom_range(0, 1) == 1);
      ru = ($urandom_range(0, 9) < 4);
      applyStimulus(rr, rq, 32'($urandom_range(0, 511)), ru,
                    32'($urandom_range(0, 511)), 4'($urandom),
                    1'($urandom), 1'($urandom));
    end

    // Test 6: reset in the middle of the sweep restarts it
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 1, $urandom, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    cnt = 0;
    while (!ready && cnt < 100) begin
      applyStimulus(0, 1, $urandom, 1, $urandom, 4'($urandom), 1, 0);
      cnt++;
    end
    checkOutput("midsweep_ready_latency", 32'(cnt), 64);
    checkOutput("midsweep_branch_count", branch_count, 0);
    checkOutput("midsweep_mispredict_count", mispredict_count, 0);
    applyStimulus(0, 1, 32'h40, 0, 0, 0, 0, 0);
    checkOutput("midsweep_valid", 32'(predict_valid), 1);
    checkOutput("midsweep_ghr", 32'(predict_ghr), 0);
    checkOutput("midsweep_taken", 32'(predict_taken), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
